// File: rtl/down_timer.sv
// Memory-mapped down-counting timer: software loads PRESET, the block counts
// COUNT toward zero and raises an interrupt, either once or periodically.
module down_timer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic             IRQ
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic ctrl_en, ctrl_im, auto_reload;
  logic wr_ctrl, wr_preset;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_im     = ctrl_q[3];
  assign auto_reload = (ctrl_q[2:1] == MODE_RELOAD);
  assign wr_ctrl     = WE && (Addr == ADDR_CTRL);
  assign wr_preset   = WE && (Addr == ADDR_PRESET);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // Software acknowledge comes first so a same-cycle expiry is not lost.
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;

    unique case (state_q)
      S_IDLE: if (ctrl_en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      S_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the FSM so a software CTRL write overrides the En clear.
    if (wr_ctrl)   ctrl_d   = DataIn[3:0];
    if (wr_preset) preset_d = DataIn;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    DataOut = '0;
    unique case (Addr)
      ADDR_CTRL:   DataOut = {{(WIDTH-4){1'b0}}, ctrl_q};
      ADDR_PRESET: DataOut = preset_q;
      ADDR_COUNT:  DataOut = count_q;
      default:     DataOut = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_im;

endmodule
